// File: rtl/regfile_sb.sv
// Register file with a per-register pending-bit scoreboard for an in-order
// pipeline: same-cycle writeback bypass, RAW/WAW stall generation, pending count.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            write_enable,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            stall,
    output logic [5:0]      pending_count
);

    localparam int AW = 5;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [5:0]       r_pending_count;

    logic [NREGS-1:0] w_clear_hit;
    logic [NREGS-1:0] w_set_hit;
    logic [NREGS-1:0] w_live;
    logic [NREGS-1:0] w_pending_next;
    logic [5:0]       w_count_next;
    logic             w_rs1_block;
    logic             w_rs2_block;
    logic             w_waw_block;
    logic             w_rs1_valid;
    logic             w_rs2_valid;
    logic             w_rd_valid;
    logic             w_issue_valid_rd;
    logic [XLEN-1:0]  w_rs1_stored;
    logic [XLEN-1:0]  w_rs2_stored;

    // Address 0 is hardwired zero, and addresses beyond NREGS are treated the same way.
    assign w_rs1_valid      = (rs1_addr != '0) && (int'(rs1_addr) < NREGS);
    assign w_rs2_valid      = (rs2_addr != '0) && (int'(rs2_addr) < NREGS);
    assign w_rd_valid       = (rd_addr  != '0) && (int'(rd_addr)  < NREGS);
    assign w_issue_valid_rd = (issue_rd != '0) && (int'(issue_rd) < NREGS);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_clear_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_clear_hit[r] = write_enable && (rd_addr == AW'(r));
        end
    end

    // A pending bit being cleared this cycle no longer hazards: its value arrives on the bypass.
    assign w_live = r_pending & ~w_clear_hit;

    assign w_rs1_block = rs1_used && w_rs1_valid && w_live[rs1_addr];
    assign w_rs2_block = rs2_used && w_rs2_valid && w_live[rs2_addr];
    assign w_waw_block = issue_valid && w_issue_valid_rd && w_live[issue_rd];
    assign stall       = w_rs1_block || w_rs2_block || w_waw_block;

    always_comb begin
        w_set_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_set_hit[r] = issue_valid && !stall && (issue_rd == AW'(r));
        end
    end

    // Set beats clear: a new producer issuing as the old one writes back keeps the register busy.
    always_comb begin
        w_pending_next = (r_pending | w_set_hit) & ~(w_clear_hit & ~w_set_hit);
        w_count_next   = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_count_next = w_count_next + 6'(w_pending_next[r]);
        end
    end

    assign w_rs1_stored = w_rs1_valid ? r_regs[rs1_addr] : '0;
    assign w_rs2_stored = w_rs2_valid ? r_regs[rs2_addr] : '0;

    assign rs1_data = (write_enable && w_rd_valid && (rd_addr == rs1_addr)) ? rd_data : w_rs1_stored;
    assign rs2_data = (write_enable && w_rd_valid && (rd_addr == rs2_addr)) ? rd_data : w_rs2_stored;

    // NOTE: the storage array is reset along with the scoreboard, so it is flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_pending       <= '0;
            r_pending_count <= '0;
        end else begin
            if (write_enable && w_rd_valid) begin
                r_regs[rd_addr] <= rd_data;
            end
            r_pending       <= w_pending_next;
            r_pending_count <= w_count_next;
        end
    end

    assign pending_count = r_pending_count;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, x0 handling, RAW/WAW stalls,
// set-over-clear priority and asynchronous reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
    logic        rs1_used, rs2_used, write_enable, issue_valid;
    logic [31:0] rd_data, rs1_data, rs2_data;
    logic        stall;
    logic [5:0]  pending_count;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.XLEN(32), .NREGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .write_enable (write_enable),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        write_enable = 1'b0; rd_addr = '0; rd_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #3;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", pending_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1: got %h expected 0", rs1_data); end
        checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rs2: got %h expected 0", rs2_data); end
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL reset_hold_count: got %0d expected 0", pending_count); end
        idle_inputs();
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read_bypass();
        write_enable = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1: got %h expected deadbeef", rs1_data); end
        checks++; if (rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2: got %h expected deadbeef", rs2_data); end
        tick();
        write_enable = 1'b0; rd_data = '0;
        #1;
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_rs1: got %h expected deadbeef", rs1_data); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL write_no_pending: got %0d expected 0", pending_count); end
        idle_inputs();
    endtask

    task automatic test_x0();
        write_enable = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rs1_used = 1'b1;
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_nobypass: got %h expected 0", rs1_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_read: got %h expected 0", rs1_data); end
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL x0_count: got %0d expected 0", pending_count); end
    endtask

    task automatic test_raw_stall();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_inputs();
        rs2_used = 1'b1; rs2_addr = 5'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL raw_count: got %0d expected 1", pending_count); end
        write_enable = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", stall); end
        checks++; if (rs2_data !== 32'h12345678) begin errors++; $display("FAIL raw_bypass: got %h expected 12345678", rs2_data); end
        tick();
        write_enable = 1'b0;
        #1;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL raw_cleared: got %0d expected 0", pending_count); end
        checks++; if (rs2_data !== 32'h12345678) begin errors++; $display("FAIL raw_stored: got %h expected 12345678", rs2_data); end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL setwin_pre: got %0d expected 1", pending_count); end
        write_enable = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5A5A5;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL setwin_stall: got %b expected 0", stall); end
        tick();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL setwin_count: got %0d expected 1", pending_count); end
        idle_inputs();
        rs1_used = 1'b1; rs1_addr = 5'd3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL setwin_still_busy: got %b expected 1", stall); end
        checks++; if (rs1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL setwin_data: got %h expected a5a5a5a5", rs1_data); end
        write_enable = 1'b1; rd_addr = 5'd3; rd_data = 32'h33333333;
        tick();
        idle_inputs();
        #1;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL setwin_clear: got %0d expected 0", pending_count); end
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", stall); end
        tick();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL waw_count: got %0d expected 1", pending_count); end
        issue_valid = 1'b0; rs1_used = 1'b0; rs1_addr = 5'd9;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_unused_src: got %b expected 0", stall); end
        rs1_used = 1'b1; issue_valid = 1'b1; issue_rd = 5'd10;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL src_block: got %b expected 1", stall); end
        tick();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL stall_no_set: got %0d expected 1", pending_count); end
        idle_inputs();
        write_enable = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
        tick();
        idle_inputs();
        #1;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL waw_clear: got %0d expected 0", pending_count); end
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1; issue_rd = 5'd1;
        write_enable = 1'b1; rd_addr = 5'd4; rd_data = 32'h44444444;
        tick();
        write_enable = 1'b0; issue_rd = 5'd2;
        tick();
        issue_rd = 5'd4;
        tick();
        idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd4; rs2_used = 1'b1;
        #1;
        checks++; if (pending_count !== 6'd3) begin errors++; $display("FAIL pre_rst_count: got %0d expected 3", pending_count); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b expected 1", stall); end
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_rst_rs1: got %h expected deadbeef", rs1_data); end
        checks++; if (rs2_data !== 32'h44444444) begin errors++; $display("FAIL pre_rst_rs2: got %h expected 44444444", rs2_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", pending_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1: got %h expected 0", rs1_data); end
        checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rst_rs2: got %h expected 0", rs2_data); end
        write_enable = 1'b1; rd_addr = 5'd5; rd_data = 32'h5555AAAA;
        #1;
        checks++; if (rs1_data !== 32'h5555AAAA) begin errors++; $display("FAIL rst_bypass: got %h expected 5555aaaa", rs1_data); end
        write_enable = 1'b0; rd_data = '0;
        #1 rst_n = 1'b1;
        tick();
        checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL post_rst_count: got %0d expected 0", pending_count); end
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL post_rst_rs1: got %h expected 0", rs1_data); end
        issue_valid = 1'b1; issue_rd = 5'd2;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b expected 0", stall); end
        tick();
        checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL post_rst_issue: got %0d expected 1", pending_count); end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read_bypass();
        test_x0();
        test_raw_stall();
        test_set_wins();
        test_waw();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
